pin_id_uart_tx: RTL
===================

// Module: pin_id_uart_tx
// PURPOSE
//  Board bring-up pin-identification transmitter: drives every pin of a wide output bus
//  with a repeating 8N1 UART frame carrying that pin's own index.
//  A probe plus logic analyzer or UART decoder on any trace reads the bus bit position
//  directly, for net mapping of unknown connectors.
//  Outbound counterpart of the all-pins input sampling top. Instantiated in that top to
//  drive the spare output bus in place of the plain counter-bit toggle.
// PARAMETERS
//  CLK_HZ     25000000  input clock frequency, Hz
//  BAUD       115200    line rate; DIV = CLK_HZ/BAUD (integer truncate, 217 at defaults)
//  NUM_PINS   163       width of pin_out; legal 1..256
//  GAP_BITS   2         idle (mark) bit periods appended after stop bit; legal 0..15
// PORTS
//  clk25        in   1         system clock
//  rst_         in   1         asynchronous active-low reset
//  ena          in   1         level; frames are sent while high
//  pin_out      out  NUM_PINS  pin i carries UART frame with data = i[7:0]
//  busy         out  1         high from START entry to end of GAP
//  frame_done   out  1         1-cycle pulse on the last cycle of each frame
//  frame_cnt    out  16        completed-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, rst_=0): pin_out all 1 (mark), busy=0, frame_done=0, frame_cnt=0, state IDLE, baud/bit counters 0.
//  - All outputs registered. FSM: IDLE -> START -> DATA(8) -> [PARITY] -> STOP -> GAP -> IDLE|START.
//  - Baud counter 0..DIV-1, restarts on every state entry. Each START/DATA/PARITY/STOP/GAP bit lasts exactly DIV cycles.
//  - IDLE: ena sampled 1 at edge n -> START; pin_out all 0 and busy=1 from edge n+1.
//  - DATA: bits LSB first. During data bit b, pin_out[i] = i[b] for every i.
//  - STOP: all 1 for one bit. GAP: all 1 for GAP_BITS bits (GAP_BITS=0 skips GAP).
//  - Frame length: (10+GAP_BITS)*DIV cycles without parity (12*217=2604 default), +DIV with parity.
//  - frame_done=1 and frame_cnt+1 on the final cycle of the last mark bit.
//  - Next edge: ena=1 -> START directly (no idle cycle, busy stays 1); ena=0 -> IDLE, busy=0.
//  - ena dropped mid-frame: current frame completes unchanged; ena changes outside IDLE/frame end are ignored.
//  - rst_ mid-frame: immediate return to reset values; no partial-frame completion, no frame_done.
//  - Index width: pins 0..NUM_PINS-1 fit 8 bits; NUM_PINS>256 is a parameter error (elaboration $error).
//  - DIV<2 (BAUD > CLK_HZ/2) is a parameter error.
// CONFIGURATION
//  PIN_ID_PARITY_EN defined: a PARITY bit follows DATA. pin_out[i] = ^i[7:0] (even parity),
//    duration DIV; frame is 8E1.
//  Undefined: no PARITY state, frame is 8N1; no parity logic synthesized.
// TESTING
//  1 Assert rst_=0, ena=0 -> pin_out all 1, busy=0, frame_done=0, frame_cnt=0.
//  2 Release reset, pulse ena for 1 cycle ->
//    a. pin_out[5] for 217 cycles each: 0,1,0,1,0,0,0,0,0, then 1,1,1.
//    b. frame_done single pulse 2604 cycles after the START edge.
//    c. busy then drops, frame_cnt=1, pins stay at 1.
//  3 Pin 162 (0xA2), same run -> data bits 0,1,0,0,0,1,0,1; pin 0 all data 0; pin 255 (NUM_PINS=256) all data 1.
//  4 Hold ena=1 for 3 frames ->
//    a. START begins the cycle after each frame_done; busy never drops.
//    b. frame_cnt=3; frame_cnt preset near 0xFFFF wraps to 0.
//  5 Assert rst_=0 during DATA bit 4 -> pin_out all 1 same cycle, busy=0, frame_cnt unchanged at 0, no frame_done.
//  6 Build with PIN_ID_PARITY_EN -> pin 7 parity bit 1, pin 3 parity bit 0, frame length 13*217=2821 cycles.
//    Without the macro, frame length 2604 cycles.

Source files
------------

// File: rtl/pin_id_uart_tx.sv
// ============================================================================
// Module   : pin_id_uart_tx
// Brief    : Pin-identification UART transmitter. Every bit of pin_out carries
//            a repeating UART frame whose data byte is that pin's own index,
//            so a probe on any trace reveals its bus bit position.
// Config   : PIN_ID_PARITY_EN - adds an even-parity bit after the data (8E1);
//            left undefined the frame is 8N1 with no parity logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_id_uart_tx #(
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned NUM_PINS = 163,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic                clk25,
    input  logic                rst_,
    input  logic                ena,
    output logic [NUM_PINS-1:0] pin_out,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned c_DIV = CLK_HZ / BAUD;
    localparam int unsigned c_CW  = (c_DIV < 2) ? 1 : $clog2(c_DIV);

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(c_DIV - 1);
    // frame_done is registered, so it is armed one cycle before the last cycle
    localparam logic [c_CW-1:0] c_DONE_AT   = c_CW'(c_DIV - 2);
    localparam bit              c_HAS_GAP   = (GAP_BITS != 0);
    localparam logic [3:0]      c_LAST_GAP  = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

    // Parameter legality checks, evaluated at elaboration
    if (NUM_PINS < 1 || NUM_PINS > 256) begin : g_bad_pins
        $error("pin_id_uart_tx: NUM_PINS must be 1..256");
    end
    if (c_DIV < 2) begin : g_bad_div
        $error("pin_id_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (GAP_BITS > 15) begin : g_bad_gap
        $error("pin_id_uart_tx: GAP_BITS must be 0..15");
    end

`ifdef PIN_ID_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;
`endif

    // Bus pattern for data bit b: pin i drives bit b of its own 8-bit index
    function automatic logic [NUM_PINS-1:0] f_data_pat(input logic [2:0] b);
        logic [NUM_PINS-1:0] p;
        logic [7:0]          idx;
        for (int i = 0; i < NUM_PINS; i++) begin
            idx  = 8'(i);
            p[i] = idx[b];
        end
        return p;
    endfunction

`ifdef PIN_ID_PARITY_EN
    // Bus pattern for the even-parity bit of each pin's index
    function automatic logic [NUM_PINS-1:0] f_parity_pat();
        logic [NUM_PINS-1:0] p;
        logic [7:0]          idx;
        for (int i = 0; i < NUM_PINS; i++) begin
            idx  = 8'(i);
            p[i] = ^idx;
        end
        return p;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [c_CW-1:0]     baud_q, baud_d;
    logic [3:0]          bit_q, bit_d;
    logic [NUM_PINS-1:0] pin_q, pin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                w_bit_end;
    logic                w_frame_end;
    logic                w_last_mark;

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            pin_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, bit timing and next bus value
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_d       = bit_q;
        pin_d       = pin_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        w_frame_end = 1'b0;
        w_bit_end   = (baud_q == c_BAUD_LAST);
        w_last_mark = ((state_q == ST_STOP) && !c_HAS_GAP) ||
                      ((state_q == ST_GAP) && (bit_q == c_LAST_GAP));

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (ena) begin
                    state_d = ST_START;
                    pin_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    pin_d   = f_data_pat(3'd0);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_q == 4'd7) begin
                        bit_d   = 4'd0;
`ifdef PIN_ID_PARITY_EN
                        state_d = ST_PARITY;
                        pin_d   = f_parity_pat();
`else
                        state_d = ST_STOP;
                        pin_d   = '1;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                        pin_d = f_data_pat(bit_q[2:0] + 3'd1);
                    end
                end
            end
`ifdef PIN_ID_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                    pin_d   = '1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (c_HAS_GAP) begin
                        state_d = ST_GAP;
                        bit_d   = 4'd0;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_q == c_LAST_GAP) begin
                        w_frame_end = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                pin_d   = '1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame boundary: ena decides between a back-to-back frame and idle
        if (w_frame_end) begin
            bit_d = '0;
            if (ena) begin
                state_d = ST_START;
                pin_d   = '0;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                pin_d   = '1;
                busy_d  = 1'b0;
            end
        end

        // Pulse and count on the final cycle of the last mark bit
        if (w_last_mark && (baud_q == c_DONE_AT)) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
        end
    end

    assign pin_out    = pin_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule

`default_nettype wire
